// File: rtl/top_id.sv
// MIPS instruction-decode stage: register file with write-through, decoder,
// hazard detection, branch/jump resolution in ID, and the ID/EX register.
module top_id #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pc_in,
  input  logic [31:0]   ins_in,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          mem_regwrite,
  input  logic          mem_memread,
  input  logic [4:0]    mem_wreg,
  output logic          pcsrc,
  output logic [DW-1:0] baddr,
  output logic          Jump,
  output logic [DW-1:0] jaddr,
  output logic          Flush,
  output logic          stall,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_wreg,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_alusrc,
  output logic [2:0]    ex_aluctl
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    wreg;
    logic          regwrite;
    logic          memtoreg;
    logic          memread;
    logic          memwrite;
    logic          alusrc;
    logic [2:0]    aluctl;
  } idex_t;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  idex_t         idex_q, idex_d, dec;

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd;
  logic [DW-1:0] imm_sext, rs_val, rt_val;
  logic          use_rs, use_rt, is_beq, is_bne, is_j;
  logic          load_use, br_stall, taken;

  assign opcode   = ins_in[31:26];
  assign funct    = ins_in[5:0];
  assign rs       = ins_in[25:21];
  assign rt       = ins_in[20:16];
  assign rd       = ins_in[15:11];
  assign imm_sext = {{(DW-16){ins_in[15]}}, ins_in[15:0]};

  // Write-through: a WB write this cycle is visible to the ID read.
  assign rs_val = (rs == 5'd0) ? '0 :
                  (wb_we && wb_addr == rs) ? wb_data : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 :
                  (wb_we && wb_addr == rt) ? wb_data : regs_q[rt];

  always_comb begin
    regs_d = regs_q;
    if (wb_we && wb_addr != 5'd0) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    dec         = '0;
    dec.pc      = pc_in;
    dec.rs_data = rs_val;
    dec.rt_data = rt_val;
    dec.imm     = imm_sext;
    dec.rs      = rs;
    dec.rt      = rt;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_j        = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: dec.aluctl = 3'b010;
          6'h22: dec.aluctl = 3'b110;
          6'h24: dec.aluctl = 3'b000;
          6'h25: dec.aluctl = 3'b001;
          6'h2A: dec.aluctl = 3'b111;
          default: dec.aluctl = 3'b000;
        endcase
        if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          dec.regwrite = 1'b1;
          dec.wreg     = rd;
          use_rs       = 1'b1;
          use_rt       = 1'b1;
        end
      end
      6'h23: begin
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluctl   = 3'b010;
        dec.wreg     = rt;
        use_rs       = 1'b1;
      end
      6'h2B: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluctl   = 3'b010;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
      end
      6'h08: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluctl   = 3'b010;
        dec.wreg     = rt;
        use_rs       = 1'b1;
      end
      6'h04: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'h05: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      6'h02: is_j = 1'b1;
      default: ;
    endcase
  end

  // stall is a hold request: while high, upstream keeps pc_in/ins_in stable
  // and this stage inserts a bubble into ID/EX instead of the decoded word.
  always_comb begin
    load_use = idex_q.memread && idex_q.wreg != 5'd0 &&
               ((use_rs && idex_q.wreg == rs) || (use_rt && idex_q.wreg == rt));
    br_stall = 1'b0;
    if (is_beq || is_bne) begin
      // No MEM data port exists, so any MEM-stage writer of a source also stalls.
      if (rs != 5'd0 && ((idex_q.regwrite && idex_q.wreg == rs) ||
          ((mem_memread || mem_regwrite) && mem_wreg == rs)))
        br_stall = 1'b1;
      if (rt != 5'd0 && ((idex_q.regwrite && idex_q.wreg == rt) ||
          ((mem_memread || mem_regwrite) && mem_wreg == rt)))
        br_stall = 1'b1;
    end
    stall  = load_use || br_stall;
    taken  = !stall && ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val));
    pcsrc  = taken;
    Jump   = is_j && !stall;
    Flush  = taken || (is_j && !stall);
    baddr  = pc_in + {imm_sext[DW-3:0], 2'b00};
    jaddr  = {pc_in[31:28], ins_in[25:0], 2'b00};
    idex_d = stall ? '0 : dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      idex_q <= '0;
    end else begin
      regs_q <= regs_d;
      idex_q <= idex_d;
    end
  end

  assign ex_pc       = idex_q.pc;
  assign ex_rs_data  = idex_q.rs_data;
  assign ex_rt_data  = idex_q.rt_data;
  assign ex_imm      = idex_q.imm;
  assign ex_rs       = idex_q.rs;
  assign ex_rt       = idex_q.rt;
  assign ex_wreg     = idex_q.wreg;
  assign ex_regwrite = idex_q.regwrite;
  assign ex_memtoreg = idex_q.memtoreg;
  assign ex_memread  = idex_q.memread;
  assign ex_memwrite = idex_q.memwrite;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_aluctl   = idex_q.aluctl;

endmodule

// File: tb/tb_top_id.sv
// Directed bench for the ID stage: decode, write-through, hazards, redirects, reset.
module tb_top_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, ins_in, wb_data;
  logic        wb_we, mem_regwrite, mem_memread;
  logic [4:0]  wb_addr, mem_wreg;
  logic        pcsrc, Jump, Flush, stall;
  logic [31:0] baddr, jaddr;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_alusrc;
  logic [2:0]  ex_aluctl;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  top_id dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .ins_in(ins_in),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .pcsrc(pcsrc), .baddr(baddr), .Jump(Jump), .jaddr(jaddr), .Flush(Flush),
    .stall(stall), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_aluctl(ex_aluctl)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] exp_rs);
    pc_in  = pc;
    ins_in = ins;
    exp_q.push_back(exp_rs);
    #1;
  endtask

  task automatic check_rs(input string tag);
    if (exp_q.size() == 0) check({tag, "_noexp"}, 32'd1, 32'd0);
    else check(tag, ex_rs_data, exp_q.pop_front());
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d; ins_in = 32'h0;
    step();
    wb_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_in = 0; ins_in = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    mem_regwrite = 0; mem_memread = 0; mem_wreg = 0;
    #1;
    check("rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;

    // Basic add after a WB write of r5
    wb_write(5'd5, 32'h1234);
    present(32'h40, 32'h00A51820, 32'h1234);   // add r3,r5,r5
    step();
    check_rs("add_rs");
    check("add_rt", ex_rt_data, 32'h1234);
    check("add_wreg", {27'd0, ex_wreg}, 32'd3);
    check("add_aluctl", {29'd0, ex_aluctl}, 32'd2);
    check("add_regwrite", {31'd0, ex_regwrite}, 32'd1);
    check("add_alusrc", {31'd0, ex_alusrc}, 32'd0);
    check("add_pc", ex_pc, 32'h40);

    // Same-cycle write-through, then stored value, then r0 writes ignored
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
    present(32'h44, 32'h00E04020, 32'hDEAD);   // add r8,r7,r0
    step();
    wb_we = 1'b0;
    check_rs("wt_rs");
    check("wt_rt", ex_rt_data, 32'd0);
    present(32'h48, 32'h00E04020, 32'hDEAD);
    step();
    check_rs("stored_rs");
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    present(32'h4C, 32'h00004820, 32'h0);      // add r9,r0,r0
    step();
    wb_we = 1'b0;
    check_rs("r0_wt_rs");
    present(32'h50, 32'h00004820, 32'h0);
    step();
    check_rs("r0_stored_rs");
    check("r0_wreg", {27'd0, ex_wreg}, 32'd9);

    // Load-use stall
    wb_write(5'd1, 32'h11);
    wb_write(5'd3, 32'h33);
    present(32'h60, 32'h8C220000, 32'h11);     // lw r2,0(r1)
    step();
    check_rs("lw_rs");
    check("lw_memread", {31'd0, ex_memread}, 32'd1);
    check("lw_memtoreg", {31'd0, ex_memtoreg}, 32'd1);
    check("lw_alusrc", {31'd0, ex_alusrc}, 32'd1);
    check("lw_wreg", {27'd0, ex_wreg}, 32'd2);
    pc_in = 32'h64; ins_in = 32'h00432020;     // add r4,r2,r3
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble_rw", {31'd0, ex_regwrite}, 32'd0);
    check("lu_bubble_mr", {31'd0, ex_memread}, 32'd0);
    check("lu_release", {31'd0, stall}, 32'd0);
    exp_q.push_back(32'h0);
    step();
    check_rs("lu_add_rs");
    check("lu_add_rt", ex_rt_data, 32'h33);
    check("lu_add_wreg", {27'd0, ex_wreg}, 32'd4);
    check("lu_add_rw", {31'd0, ex_regwrite}, 32'd1);

    // sw and sub decode
    present(32'h70, 32'hAC230004, 32'h11);     // sw r3,4(r1)
    step();
    check_rs("sw_rs");
    check("sw_memwrite", {31'd0, ex_memwrite}, 32'd1);
    check("sw_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("sw_imm", ex_imm, 32'd4);
    check("sw_rt", ex_rt_data, 32'h33);
    present(32'h74, 32'h00615022, 32'h33);     // sub r10,r3,r1
    step();
    check_rs("sub_rs");
    check("sub_aluctl", {29'd0, ex_aluctl}, 32'd6);
    check("sub_wreg", {27'd0, ex_wreg}, 32'd10);

    // Branches (EX holds sub r10: no conflict with r0/r1/r3)
    pc_in = 32'h100; ins_in = 32'h10210003;    // beq r1,r1,+3
    #1;
    check("beq_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("beq_baddr", baddr, 32'h10C);
    check("beq_flush", {31'd0, Flush}, 32'd1);
    check("beq_jump", {31'd0, Jump}, 32'd0);
    ins_in = 32'h14210003;                     // bne r1,r1,+3
    #1;
    check("bne_eq_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("bne_eq_flush", {31'd0, Flush}, 32'd0);
    ins_in = 32'h1000FFFF;                     // beq r0,r0,-1
    #1;
    check("beq_neg_baddr", baddr, 32'hFC);
    check("beq_neg_pcsrc", {31'd0, pcsrc}, 32'd1);
    pc_in = 32'h200; ins_in = 32'h14230002;    // bne r1,r3,+2
    #1;
    check("bne_ne_pcsrc", {31'd0, pcsrc}, 32'd1);
    check("bne_ne_baddr", baddr, 32'h208);
    step();
    check("br_bubble_rw", {31'd0, ex_regwrite}, 32'd0);

    // Jump
    pc_in = 32'h1000_0004; ins_in = 32'h08000040;
    #1;
    check("j_jump", {31'd0, Jump}, 32'd1);
    check("j_jaddr", jaddr, 32'h1000_0100);
    check("j_flush", {31'd0, Flush}, 32'd1);
    check("j_pcsrc", {31'd0, pcsrc}, 32'd0);

    // Branch hazards against EX and MEM
    present(32'h300, 32'h20060005, 32'h0);     // addi r6,r0,5
    step();
    check_rs("addi_rs");
    check("addi_imm", ex_imm, 32'd5);
    check("addi_wreg", {27'd0, ex_wreg}, 32'd6);
    pc_in = 32'h304; ins_in = 32'h10C00001;    // beq r6,r0,+1
    #1;
    check("bh_ex_stall", {31'd0, stall}, 32'd1);
    check("bh_ex_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("bh_ex_flush", {31'd0, Flush}, 32'd0);
    step();
    check("bh_bubble", {31'd0, ex_regwrite}, 32'd0);
    check("bh_clear_pcsrc", {31'd0, pcsrc}, 32'd1);
    mem_regwrite = 1'b1; mem_wreg = 5'd6;
    #1;
    check("bh_mem_stall", {31'd0, stall}, 32'd1);
    check("bh_mem_pcsrc", {31'd0, pcsrc}, 32'd0);
    mem_regwrite = 1'b0; mem_memread = 1'b1;
    #1;
    check("bh_memld_stall", {31'd0, stall}, 32'd1);
    mem_memread = 1'b0; mem_wreg = 5'd0;

    // Asynchronous reset mid-stream
    present(32'h400, 32'h00A51820, 32'h1234);
    step();
    check_rs("pre_rst_rs");
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rw", {31'd0, ex_regwrite}, 32'd0);
    check("mid_rst_wreg", {27'd0, ex_wreg}, 32'd0);
    check("mid_rst_rs", ex_rs_data, 32'd0);
    #1 rst = 1'b0;
    exp_q.push_back(32'h0);
    step();
    check_rs("post_rst_rs");
    check("post_rst_wreg", {27'd0, ex_wreg}, 32'd3);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
